// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: sequencer states and default width.
package bit_serial_adder_pkg;

    localparam int unsigned ADDER_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/bit_serial_adder_fa.sv
// One-bit full adder built from gate primitives; the serial adder's only datapath cell.
module fulladder_structural_description (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic axb;
    logic gen;
    logic prop;

    xor u_x1 (axb, a, b);
    xor u_x2 (s, axb, cin);
    and u_a1 (gen, a, b);
    and u_a2 (prop, axb, cin);
    or  u_o1 (cout, gen, prop);

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial WIDTH-bit adder: loads operands on start, adds LSB first through one
// full adder with a registered carry, then publishes sum/cout with a done pulse.
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             fa_s;
    logic             fa_cout;
    logic [WIDTH-1:0] sum_next;
    logic             last_bit;

    fulladder_structural_description u_fa (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (c_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // Shift-in form that stays legal when WIDTH == 1 (no [WIDTH-1:1] slice).
    assign sum_next = (sum_sr_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        sum_d    = sum_q;
        c_d      = c_q;
        cout_d   = cout_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    c_d     = cin;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                c_d      = fa_cout;
                sum_sr_d = sum_next;
                if (last_bit) begin
                    // Counter parks at zero so it never reaches WIDTH.
                    cnt_d   = '0;
                    sum_d   = sum_next;
                    cout_d  = fa_cout;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            sum_q    <= '0;
            c_q      <= 1'b0;
            cout_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            sum_q    <= sum_d;
            c_q      <= c_d;
            cout_q   <= cout_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy = (state_q == ST_SHIFT);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Bench for bit_serial_adder: arithmetic reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_bit_serial_adder;

    localparam int unsigned WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit en = 1'b0;

    bit_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: an accepted start schedules the result a+b+cin to appear WIDTH edges later.
    logic             m_busy = 1'b0;
    logic             m_done = 1'b0;
    logic [WIDTH-1:0] m_sum = '0;
    logic             m_cout = 1'b0;
    logic [WIDTH:0]   pend = '0;
    int               rem = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_sum = '0; m_cout = 1'b0; rem = 0;
        end else if (!m_busy) begin
            m_done = 1'b0;
            if (start) begin
                pend   = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
                rem    = WIDTH;
                m_busy = 1'b1;
            end
        end else begin
            rem = rem - 1;
            if (rem == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                {m_cout, m_sum} = pend;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (en) begin
            chk("model_busy", 32'(busy), 32'(m_busy));
            chk("model_done", 32'(done), 32'(m_done));
            chk("model_sum",  32'(sum),  32'(m_sum));
            chk("model_cout", 32'(cout), 32'(m_cout));
        end
    end

    int t_acc;

    task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv);
        @(posedge clk); #2;
        start = 1'b1; a = av; b = bv; cin = cv;
        @(posedge clk); #2;
        t_acc = cyc;
        start = 1'b0; a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
    endtask

    task automatic wait_done(output bit found);
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input string name, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic cv, input logic [WIDTH-1:0] es, input logic ec);
        bit found;
        issue(av, bv, cv);
        wait_done(found);
        if (found) begin
            chk({name, "_latency"}, 32'(cyc - t_acc), 32'(WIDTH));
            chk({name, "_sum"}, 32'(sum), 32'(es));
            chk({name, "_cout"}, 32'(cout), 32'(ec));
        end
    endtask

    int done_cyc[$];

    initial begin
        bit found;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum",  32'(sum),  32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        rst = 1'b0;
        en = 1'b1;

        run_op("t2", 4'b1011, 4'b0110, 1'b0, 4'b0001, 1'b1);

        // Asynchronous reset asserted mid-cycle clears outputs without a clock edge.
        #1 rst = 1'b1;
        #1;
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_done", 32'(done), 32'd0);
        chk("async_sum",  32'(sum),  32'd0);
        chk("async_cout", 32'(cout), 32'd0);
        @(posedge clk); #2 rst = 1'b0;

        run_op("t3", 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1);

        // Second start during SHIFT must be ignored.
        issue(4'b0011, 4'b0001, 1'b0);
        @(posedge clk); #2;
        start = 1'b1; a = 4'b1111; b = 4'b1111; cin = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done(found);
        if (found) begin
            chk("t4_sum",  32'(sum),  32'b0100);
            chk("t4_cout", 32'(cout), 32'd0);
        end
        @(posedge clk); #2;
        chk("t4_idle", 32'(busy | done), 32'd0);

        // Held start: back-to-back operations every WIDTH+1 cycles.
        @(posedge clk); #2;
        start = 1'b1; a = 4'b0101; b = 4'b0101; cin = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cyc.push_back(cyc);
                chk("t5_sum",  32'(sum),  32'b1010);
                chk("t5_cout", 32'(cout), 32'd0);
            end
        end
        start = 1'b0;
        chk("t5_pulses", 32'(done_cyc.size()), 32'd3);
        for (int i = 1; i < done_cyc.size(); i++)
            chk("t5_period", 32'(done_cyc[i] - done_cyc[i-1]), 32'(WIDTH + 1));
        repeat (6) @(posedge clk);
        #2;

        // Reset during the second SHIFT cycle aborts with no done.
        issue(4'b0111, 4'b0001, 1'b0);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_sum",  32'(sum),  32'd0);
        chk("t6_cout", 32'(cout), 32'd0);
        @(posedge clk); #2 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t6_no_done", 32'(done), 32'd0);
        end
        run_op("t6b", 4'b1000, 4'b1000, 1'b1, 4'b0001, 1'b1);

        // Randomized traffic, including starts during SHIFT and occasional resets.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #2;
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 63) == 0) rst = 1'b1;
            start = ($urandom_range(0, 2) == 0);
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            cin = 1'($urandom);
        end
        @(posedge clk); #2;
        rst = 1'b0; start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
